// File: rtl/irq_plic_lite_pkg.sv
// Shared definitions for the lite platform interrupt controller: register map and gateway states.
package irq_plic_lite_pkg;

  // Width of a source ID; ID 0 means "no source".
  localparam int unsigned ID_W = 5;

  // Byte offsets of the register map.
  localparam logic [7:0] PLIC_PRIO_BASE = 8'h00;
  localparam logic [7:0] PLIC_PENDING   = 8'h80;
  localparam logic [7:0] PLIC_ENABLE    = 8'h84;
  localparam logic [7:0] PLIC_THRESH    = 8'h88;
  localparam logic [7:0] PLIC_CLAIM     = 8'h8C;

  // Per-source gateway states.
  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_e;

endpackage

// File: rtl/irq_gateway.sv
// Per-source interrupt gateway: input synchroniser, rising-edge detect, one-deep edge flag and
// the IDLE/PENDING/CLAIMED handshake state machine.
module irq_gateway
  import irq_plic_lite_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          IS_EDGE     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o
);

  logic      s;
  logic      s_prev_q;
  logic      rise;
  logic      trigger;
  logic      flag_q, flag_d;
  gw_state_e state_q, state_d;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = src_i;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw line through the synchroniser chain.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sync_q <= '0;
      end else begin
        sync_q <= SYNC_STAGES'({sync_q, src_i});
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  // Remember the previous synchronised level for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_prev_q <= 1'b0;
    end else begin
      s_prev_q <= s;
    end
  end

  assign rise    = s & ~s_prev_q;
  // An edge source also fires from an edge remembered while it was claimed.
  assign trigger = IS_EDGE ? (rise | flag_q) : s;

  // Gateway state and edge flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= GW_IDLE;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
    end
  end

  // Next-state logic for the handshake FSM and edge flag.
  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    unique case (state_q)
      GW_IDLE: begin
        if (trigger) begin
          state_d = GW_PENDING;
          flag_d  = 1'b0;
        end
      end
      GW_PENDING: begin
        if (claim_i) begin
          state_d = GW_CLAIMED;
        end
      end
      GW_CLAIMED: begin
        // Only one edge is remembered; later ones while the flag is set are dropped.
        if (IS_EDGE && rise) begin
          flag_d = 1'b1;
        end
        if (complete_i) begin
          state_d = GW_IDLE;
        end
      end
      default: begin
        state_d = GW_IDLE;
      end
    endcase
  end

  assign pending_o = (state_q == GW_PENDING);

endmodule

// File: rtl/irq_plic_lite.sv
// Lite platform-level interrupt controller: per-source gateways, priority/enable/threshold
// registers, highest-priority arbiter and a claim/complete register port.
module irq_plic_lite
  import irq_plic_lite_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned PRIO_W      = 3,
  parameter logic [31:0] EDGE_MASK   = 32'h0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC:0]   src_i,
  input  logic               reg_ce_i,
  input  logic               reg_we_i,
  input  logic [7:0]         reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [31:0]        reg_rdata_o,
  output logic               irq_external_o,
  output logic [ID_W-1:0]    claim_id_o
);

  localparam logic [ID_W-1:0] MaxId = ID_W'(NUM_SRC);

  logic [PRIO_W-1:0] prio_q [NUM_SRC:1];
  logic [NUM_SRC:1]  enable_q;
  logic [PRIO_W-1:0] thresh_q;
  logic [NUM_SRC:1]  pending;
  logic [NUM_SRC:1]  cand;

  logic [ID_W-1:0]   best_id;
  logic [PRIO_W-1:0] best_prio;

  logic [31:0]       rdata_d, rdata_q;
  logic              irq_q;
  logic [ID_W-1:0]   claim_id_q;

  logic              rd_en, wr_en;
  logic              prio_sel;
  logic [ID_W-1:0]   prio_idx;
  logic              claim_fire, complete_fire;

  // Bit 0 of the source bus is the reserved "none" ID and has no gateway.
  logic unused_src0;
  assign unused_src0 = src_i[0];

  assign rd_en    = reg_ce_i & ~reg_we_i;
  assign wr_en    = reg_ce_i & reg_we_i;
  assign prio_idx = reg_addr_i[6:2];
  // Priority window covers word-aligned offsets below 0x80; ID 0 has no register.
  assign prio_sel = (reg_addr_i[7] == PLIC_PRIO_BASE[7]) && (reg_addr_i[1:0] == 2'b00) &&
                    (prio_idx != '0) && (prio_idx <= MaxId);

  assign claim_fire    = rd_en && (reg_addr_i == PLIC_CLAIM);
  assign complete_fire = wr_en && (reg_addr_i == PLIC_CLAIM);

  // Gateways and threshold comparison, one per source.
  for (genvar g = 1; g <= NUM_SRC; g++) begin : g_src
    irq_gateway #(
      .SYNC_STAGES (SYNC_STAGES),
      .IS_EDGE     (EDGE_MASK[g])
    ) u_gw (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .src_i      (src_i[g]),
      .claim_i    (claim_fire && (best_id == ID_W'(g))),
      .complete_i (complete_fire && (reg_wdata_i == 32'(g))),
      .pending_o  (pending[g])
    );

    assign cand[g] = pending[g] & enable_q[g] & (prio_q[g] > thresh_q);
  end

  // Highest priority wins; strict compare keeps the lowest ID on ties.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int i = 1; i <= int'(NUM_SRC); i++) begin
      if (cand[i] && (prio_q[i] > best_prio)) begin
        best_id   = ID_W'(i);
        best_prio = prio_q[i];
      end
    end
  end

  // Configuration register writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 1; i <= int'(NUM_SRC); i++) begin
        prio_q[i] <= '0;
      end
      enable_q <= '0;
      thresh_q <= '0;
    end else if (wr_en) begin
      for (int i = 1; i <= int'(NUM_SRC); i++) begin
        if (prio_sel && (prio_idx == ID_W'(i))) begin
          prio_q[i] <= reg_wdata_i[PRIO_W-1:0];
        end
      end
      if (reg_addr_i == PLIC_ENABLE) begin
        enable_q <= reg_wdata_i[NUM_SRC:1];
      end
      if (reg_addr_i == PLIC_THRESH) begin
        thresh_q <= reg_wdata_i[PRIO_W-1:0];
      end
    end
  end

  // Read mux; unmapped offsets return zero.
  always_comb begin
    rdata_d = '0;
    if (prio_sel) begin
      for (int i = 1; i <= int'(NUM_SRC); i++) begin
        if (prio_idx == ID_W'(i)) begin
          rdata_d = 32'(prio_q[i]);
        end
      end
    end else begin
      case (reg_addr_i)
        PLIC_PENDING: rdata_d[NUM_SRC:1] = pending;
        PLIC_ENABLE:  rdata_d[NUM_SRC:1] = enable_q;
        PLIC_THRESH:  rdata_d = 32'(thresh_q);
        PLIC_CLAIM:   rdata_d = 32'(best_id);
        default:      rdata_d = '0;
      endcase
    end
  end

  // Registered read data, interrupt request and last-claimed ID.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      claim_id_q <= '0;
    end else begin
      irq_q <= (best_id != '0);
      if (rd_en) begin
        rdata_q <= rdata_d;
      end
      // An empty claim leaves the debug ID untouched.
      if (claim_fire && (best_id != '0)) begin
        claim_id_q <= best_id;
      end
    end
  end

  assign reg_rdata_o    = rdata_q;
  assign irq_external_o = irq_q;
  assign claim_id_o     = claim_id_q;

endmodule

// File: tb/tb_irq_plic_lite.sv
// Directed bench for irq_plic_lite: register map, arbitration, threshold, level and edge
// gateways, invalid completion and reset in the middle of a claim.
module tb_irq_plic_lite;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  src;
  logic        reg_ce;
  logic        reg_we;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        irq_ext;
  logic [4:0]  claim_id;

  int checks = 0;
  int errors = 0;

  irq_plic_lite #(
    .NUM_SRC     (8),
    .PRIO_W      (3),
    .EDGE_MASK   (32'h0000_0040),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .src_i          (src),
    .reg_ce_i       (reg_ce),
    .reg_we_i       (reg_we),
    .reg_addr_i     (reg_addr),
    .reg_wdata_i    (reg_wdata),
    .reg_rdata_o    (reg_rdata),
    .irq_external_o (irq_ext),
    .claim_id_o     (claim_id)
  );

  always #5 clk = ~clk;

  // All helpers start and end on a falling edge; the DUT samples on the rising edge between.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
    reg_ce = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge clk);
    reg_ce = 1'b0; reg_we = 1'b0;
  endtask

  task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
    reg_ce = 1'b1; reg_we = 1'b0; reg_addr = a;
    @(negedge clk);
    reg_ce = 1'b0;
    d = reg_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++; if (irq_ext !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq_ext); end
    checks++; if (claim_id !== 5'd0) begin errors++; $display("FAIL reset_claim_id: got %0d want 0", claim_id); end
    checks++; if (reg_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", reg_rdata); end
    reg_read(8'h04, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_prio1: got %h want 0", d); end
    reg_read(8'h84, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_enable: got %h want 0", d); end
    reg_read(8'h88, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_thresh: got %h want 0", d); end
    reg_read(8'h80, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h want 0", d); end
    reg_read(8'h8C, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_claim: got %h want 0", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    reg_write(8'h04, 32'hFFFF_FFFF);
    reg_read(8'h04, d);
    checks++; if (d !== 32'h7) begin errors++; $display("FAIL regs_prio_mask: got %h want 7", d); end
    reg_write(8'h00, 32'h5);
    reg_read(8'h00, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL regs_prio0: got %h want 0", d); end
    reg_write(8'h84, 32'hFFFF_FFFF);
    reg_read(8'h84, d);
    checks++; if (d !== 32'h1FE) begin errors++; $display("FAIL regs_enable_mask: got %h want 1fe", d); end
    reg_write(8'h88, 32'hFFFF_FFFD);
    reg_read(8'h88, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL regs_thresh_mask: got %h want 5", d); end
    reg_write(8'h24, 32'h3);
    reg_read(8'h24, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL regs_prio9_unmapped: got %h want 0", d); end
    reg_write(8'h90, 32'hFFFF_FFFF);
    reg_read(8'h90, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL regs_unmapped: got %h want 0", d); end
    reg_write(8'h04, 32'h0);
    reg_write(8'h84, 32'h0);
  endtask

  task automatic test_level_arb();
    logic [31:0] d;
    reg_write(8'h04, 32'd2);
    reg_write(8'h0C, 32'd5);
    reg_write(8'h84, 32'h0A);
    reg_write(8'h88, 32'd1);
    src = 9'h00A;
    tick(3);
    checks++; if (irq_ext !== 1'b0) begin errors++; $display("FAIL arb_irq_early: got %b want 0", irq_ext); end
    tick(1);
    checks++; if (irq_ext !== 1'b1) begin errors++; $display("FAIL arb_irq_latency: got %b want 1", irq_ext); end
    reg_read(8'h80, d);
    checks++; if (d !== 32'h0A) begin errors++; $display("FAIL arb_pending: got %h want 0a", d); end
    reg_read(8'h8C, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL arb_claim_first: got %0d want 3", d); end
    checks++; if (claim_id !== 5'd3) begin errors++; $display("FAIL arb_claim_id: got %0d want 3", claim_id); end
    reg_read(8'h8C, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL arb_claim_second: got %0d want 1", d); end
    reg_read(8'h8C, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL arb_claim_third: got %0d want 0", d); end
    checks++; if (irq_ext !== 1'b0) begin errors++; $display("FAIL arb_irq_drop: got %b want 0", irq_ext); end
    src = 9'h000;
    tick(4);
    reg_write(8'h8C, 32'd3);
    reg_write(8'h8C, 32'd1);
    tick(2);
    reg_read(8'h80, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL arb_pending_clear: got %h want 0", d); end
  endtask

  task automatic test_tie_break();
    logic [31:0] d;
    reg_write(8'h08, 32'd4);
    reg_write(8'h14, 32'd4);
    reg_write(8'h84, 32'h24);
    src = 9'h024;
    tick(5);
    reg_read(8'h8C, d);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL tie_claim_low_id: got %0d want 2", d); end
    reg_read(8'h8C, d);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL tie_claim_next: got %0d want 5", d); end
    src = 9'h000;
    tick(4);
    reg_write(8'h8C, 32'd2);
    reg_write(8'h8C, 32'd5);
  endtask

  task automatic test_threshold();
    logic [31:0] d;
    reg_write(8'h10, 32'd3);
    reg_write(8'h84, 32'h10);
    reg_write(8'h88, 32'd3);
    src = 9'h010;
    tick(6);
    checks++; if (irq_ext !== 1'b0) begin errors++; $display("FAIL thr_irq_blocked: got %b want 0", irq_ext); end
    reg_read(8'h80, d);
    checks++; if (d !== 32'h10) begin errors++; $display("FAIL thr_pending: got %h want 10", d); end
    reg_write(8'h88, 32'd2);
    checks++; if (irq_ext !== 1'b0) begin errors++; $display("FAIL thr_irq_one_cycle: got %b want 0", irq_ext); end
    tick(1);
    checks++; if (irq_ext !== 1'b1) begin errors++; $display("FAIL thr_irq_two_cycles: got %b want 1", irq_ext); end
    reg_read(8'h8C, d);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL thr_claim: got %0d want 4", d); end
    src = 9'h000;
    tick(4);
    reg_write(8'h8C, 32'd4);
    reg_write(8'h88, 32'd1);
  endtask

  task automatic test_level_repend();
    logic [31:0] d;
    reg_write(8'h84, 32'h02);
    src = 9'h002;
    tick(5);
    reg_read(8'h8C, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL repend_claim: got %0d want 1", d); end
    reg_write(8'h8C, 32'd1);
    reg_read(8'h80, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL repend_idle_cycle: got %h want 0", d); end
    reg_read(8'h80, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL repend_pending: got %h want 2", d); end
    reg_read(8'h8C, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL repend_reclaim: got %0d want 1", d); end
    src = 9'h000;
    tick(4);
    reg_write(8'h8C, 32'd1);
    tick(2);
    reg_read(8'h80, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL repend_low_stays_idle: got %h want 0", d); end
    checks++; if (irq_ext !== 1'b0) begin errors++; $display("FAIL repend_irq_low: got %b want 0", irq_ext); end
  endtask

  task automatic test_edge();
    logic [31:0] d;
    reg_write(8'h18, 32'd3);
    reg_write(8'h84, 32'h40);
    src = 9'h040; tick(1); src = 9'h000;
    tick(5);
    reg_read(8'h80, d);
    checks++; if (d !== 32'h40) begin errors++; $display("FAIL edge_pending_after_pulse: got %h want 40", d); end
    reg_read(8'h8C, d);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL edge_claim: got %0d want 6", d); end
    src = 9'h040; tick(1); src = 9'h000; tick(3);
    src = 9'h040; tick(1); src = 9'h000; tick(4);
    reg_read(8'h80, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_claimed_not_pending: got %h want 0", d); end
    reg_write(8'h8C, 32'd6);
    tick(2);
    reg_read(8'h80, d);
    checks++; if (d !== 32'h40) begin errors++; $display("FAIL edge_repend: got %h want 40", d); end
    reg_read(8'h8C, d);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL edge_reclaim: got %0d want 6", d); end
    reg_write(8'h8C, 32'd6);
    tick(3);
    reg_read(8'h8C, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL edge_single_repend: got %0d want 0", d); end
  endtask

  task automatic test_invalid_and_reset();
    logic [31:0] d;
    reg_write(8'h84, 32'h02);
    src = 9'h002;
    tick(5);
    reg_write(8'h8C, 32'd7);
    reg_read(8'h80, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL inv_complete7: got %h want 2", d); end
    checks++; if (claim_id !== 5'd6) begin errors++; $display("FAIL inv_claim_id_kept: got %0d want 6", claim_id); end
    reg_write(8'h8C, 32'd0);
    reg_write(8'h8C, 32'd9);
    reg_read(8'h80, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL inv_complete0_9: got %h want 2", d); end
    reg_read(8'h8C, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL rst_pre_claim: got %0d want 1", d); end
    checks++; if (claim_id !== 5'd1) begin errors++; $display("FAIL rst_pre_claim_id: got %0d want 1", claim_id); end
    src = 9'h000;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++; if (irq_ext !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq_ext); end
    checks++; if (claim_id !== 5'd0) begin errors++; $display("FAIL rst_claim_id: got %0d want 0", claim_id); end
    checks++; if (reg_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", reg_rdata); end
    reg_read(8'h04, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_prio1: got %h want 0", d); end
    reg_read(8'h84, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_enable: got %h want 0", d); end
    reg_read(8'h88, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_thresh: got %h want 0", d); end
    reg_read(8'h80, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_pending: got %h want 0", d); end
    reg_read(8'h8C, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_claim: got %0d want 0", d); end
  endtask

  initial begin
    rst = 1'b1; src = '0; reg_ce = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
    tick(3);
    rst = 1'b0;
    test_reset();
    test_regs();
    test_level_arb();
    test_tie_break();
    test_threshold();
    test_level_repend();
    test_edge();
    test_invalid_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_plic_lite.md
Name: irq_plic_lite

Overview:
- Parametrised platform-level external interrupt controller.
- Sits between NUM_SRC device interrupt lines and the core's single irq_external_i input.
- Per source, it provides:
  - a gateway (level or edge),
  - a priority register and an enable bit,
  - a global threshold,
  - a claim/complete handshake through a memory-mapped register port driven by the mem stage.

Parameters:
- NUM_SRC, 8, number of sources; source IDs 1..NUM_SRC, ID 0 reserved as "none"; legal range 1..31.
- PRIO_W, 3, priority field width; priority 0 means never interrupts.
- EDGE_MASK, 32'h0, bit i=1 makes source i edge-triggered (rising), 0 makes it level-triggered; bit 0 ignored.
- SYNC_STAGES, 2, input synchroniser depth per source; legal range 0..3.

Ports:
- clk_i, input, 1, clock.
- rst_i, input, 1, reset; synchronous, active-high.
- src_i, input, NUM_SRC+1, raw source lines; bit 0 ignored.
- reg_ce_i, input, 1, register access strobe.
- reg_we_i, input, 1, 1 = write, 0 = read.
- reg_addr_i, input, 8, byte address, word aligned.
- reg_wdata_i, input, 32, write data.
- reg_rdata_o, output, 32, read data, valid the cycle after the read strobe.
- irq_external_o, output, 1, registered interrupt request to the core.
- claim_id_o, output, 5, ID of the most recently claimed source (debug).

Behaviour:

Reset:
- Outputs: reg_rdata_o=0, irq_external_o=0, claim_id_o=0.
- Registers: all priorities=0, enable=0, threshold=0.
- Synchronisers cleared, all gateways IDLE, edge flags cleared.
- Reset asserted mid-handshake discards any claimed state; no completion is required afterwards.

Register map (word offsets):
- 0x00+4*i: priority of source i, low PRIO_W bits R/W, upper bits read 0. Offset 0x00 reads 0 and ignores writes.
- 0x80: pending bits, read-only.
- 0x84: enable bits [NUM_SRC:1], R/W; bit 0 reads 0.
- 0x88: threshold, low PRIO_W bits R/W.
- 0x8C: claim on read, complete on write.
- Unmapped addresses read 0 and ignore writes.

Gateway FSM, per source (s = synchronised line):
- IDLE -> PENDING when the trigger condition holds:
  - level source: s=1;
  - edge source: 0->1 transition of s, or edge flag set.
- PENDING -> CLAIMED on a claim read that selects this ID.
- CLAIMED -> IDLE on a complete write carrying this ID.
- Edge source in CLAIMED: a rising edge sets a one-deep edge flag. The flag is consumed on return to IDLE, which re-pends next cycle. Further edges while the flag is set are lost.
- Level source: if s is still high after completion, it re-pends the following cycle.
- Writes of an ID not in CLAIMED, ID 0, or ID > NUM_SRC are ignored.

Arbitration (combinational over the pending array):
- Candidates: pending & enabled & prio>threshold.
- Winner = highest priority; ties go to the lowest ID.
- best_id = 0 when there are no candidates.

Interrupt request:
- irq_external_o is registered: irq_external_o <= (best_id != 0).
- Latency: source rises at cycle n -> s at n+SYNC_STAGES -> pending at n+SYNC_STAGES+1 -> irq_external_o at n+SYNC_STAGES+2.

Claim read:
- reg_rdata_o <= best_id (sampled in the strobe cycle).
- The winner moves to CLAIMED in the same edge, and claim_id_o <= best_id.
- With best_id=0: returns 0 and no state changes.

Simultaneous events:
- Claim read in the same cycle as a new source assertion: the arbitration result sampled that cycle wins; the new source pends normally.
- Complete write and priority/enable writes in the same cycle: impossible, since there is one access per cycle.
- Disabling or lowering priority of a PENDING source leaves it pending but removes it from arbitration.
- Disabling a CLAIMED source does not block its completion.

Decomposition:
- Shared defines file:
  - register offsets: PLIC_PRIO_BASE, PLIC_PENDING, PLIC_ENABLE, PLIC_THRESH, PLIC_CLAIM;
  - gateway state encodings: GW_IDLE, GW_PENDING, GW_CLAIMED.
- Sub-module irq_gateway, one instance per source: synchroniser, edge detect, edge flag, 3-state FSM.
- Top level holds: registers, arbiter (generate-loop compare), read mux.

Test Plan:
1. Level arbitration: src1 prio 2, src3 prio 5, both enabled, threshold 1, both lines high -> irq_external_o=1 at cycle SYNC_STAGES+2; claim read returns 3, next claim returns 1, third returns 0.
2. Tie-break: src2 and src5 both prio 4 and pending -> claim returns 2.
3. Threshold: src4 prio 3, threshold 3 -> irq_external_o stays 0; threshold write 2 -> irq_external_o=1 two cycles later; claim returns 4.
4. Level re-pend: claim src1, keep line high, write 1 to 0x8C -> pending bit 1 set again the cycle after completion; with the line low it stays IDLE.
5. Edge mode, EDGE_MASK bit6=1: pulse src6, claim, pulse twice more while CLAIMED, complete 6 -> exactly one re-pend (claim returns 6 once more, then 0).
6. Invalid complete and reset mid-claim: write 7 when not claimed -> no change; claim src1, assert rst_i for 1 cycle -> all registers 0, irq_external_o=0, claim returns 0.
